// File: rtl/truth_table_pkg.sv
// Shared types and sizing for the truth-table extractor.
package truth_table_pkg;

  localparam int ROWS   = 8;  // one row per input combination of a 3-input gate
  localparam int CODE_W = 8;  // one code bit per row
  localparam int ROW_W  = 3;  // row index width
  localparam int CNT_W  = 8;  // settle counter width

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

  // Row 000 lands in the MSB of the code and row 111 in the LSB.
  function automatic logic [ROW_W-1:0] code_bit(input logic [ROW_W-1:0] row);
    return ROW_W'(ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the asynchronous bit through two flop stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all eight input rows of a 3-input gate, samples its synchronized
// output after a settle delay and assembles the 8-bit truth-table code.
module truth_table_extractor
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CODE_W-1:0] expected,
  input  logic              dut_out,
  output logic [ROW_W-1:0]  dut_in,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              match
);

  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ROW_W-1:0]  dut_in_q, dut_in_d;
  logic              armed_q, armed_d;
  logic              sync_out;

  // Bring the gate output into the clk domain before it is sampled.
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (sync_out)
  );

  // Next-state and registered-output logic for the sweep FSM.
  // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    settle_d     = settle_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    match_d      = match_q;
    done_d       = 1'b0;
    // Goes high on the first edge after reset release, so a start
    // seen on that very edge is not accepted.
    armed_d      = 1'b1;

    case (state_q)
      IDLE: begin
        // Abort wins over a simultaneous start.
        if (start && !abort && armed_q) begin
          state_d      = DRIVE;
          row_d        = '0;
          settle_d     = '0;
          code_d       = '0;
          code_valid_d = 1'b0;
          match_d      = 1'b0;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_d      = IDLE;
          code_valid_d = 1'b0;
          match_d      = 1'b0;
        end else if (settle_q == LAST_SETTLE) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_d      = IDLE;
          code_valid_d = 1'b0;
          match_d      = 1'b0;
        end else begin
          code_d[code_bit(row_q)] = sync_out;
          if (row_q == LAST_ROW) begin
            // Publish the result on the same edge that enters FINISH so
            // code_valid and match are already valid while done pulses.
            state_d      = FINISH;
            done_d       = 1'b1;
            code_valid_d = 1'b1;
            match_d      = (code_d == expected);
          end else begin
            state_d  = DRIVE;
            row_d    = row_q + ROW_W'(1);
            settle_d = '0;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        if (abort) begin
          code_valid_d = 1'b0;
          match_d      = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Stimulus and busy follow the state being entered, so they line up
    // with that state's cycles.
    busy_d   = (state_d == DRIVE) || (state_d == SAMPLE);
    dut_in_d = busy_d ? row_d : '0;
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      settle_q     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      match_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      dut_in_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      match_q      <= match_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      dut_in_q     <= dut_in_d;
      armed_q      <= armed_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign match      = match_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor: default-settle instance driving
// a combinational gate model, plus a SETTLE_CYCLES=3 instance driving a gate
// model with a two-stage output delay.
module tb_truth_table_extractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'hC5;

  // Default instance signals.
  logic [7:0] gate_tt = 8'hC5;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy, done, code_valid, match;
  logic [7:0] code;

  // SETTLE_CYCLES=3 instance signals.
  logic [7:0] gate3_tt = 8'hC5;
  logic       gate3_s1 = 1'b0;
  logic       gate3_s2 = 1'b0;
  logic [2:0] dut_in3;
  logic       busy3, done3, code_valid3, match3;
  logic [7:0] code3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Combinational gate: row r drives truth-table bit (7 - r).
  assign dut_out = gate_tt[3'd7 - dut_in];

  // Delayed gate: two pipeline stages on the falling edge.
  always @(negedge clk) begin
    gate3_s1 <= gate3_tt[3'd7 - dut_in3];
    gate3_s2 <= gate3_s1;
  end

  truth_table_extractor u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .expected   (expected),
    .dut_out    (dut_out),
    .dut_in     (dut_in),
    .busy       (busy),
    .done       (done),
    .code       (code),
    .code_valid (code_valid),
    .match      (match)
  );

  truth_table_extractor #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .abort      (abort),
    .expected   (expected),
    .dut_out    (gate3_s2),
    .dut_in     (dut_in3),
    .busy       (busy3),
    .done       (done3),
    .code       (code3),
    .code_valid (code_valid3),
    .match      (match3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns 1 ns into cycle 1 of the sweep.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs a 60-cycle window after a start pulse and records observations.
  task automatic sweep(input logic repulse,
                       output int first_done, output int ndone,
                       output logic [7:0] c, output logic cv, output logic m,
                       output logic busy_at_done, output logic [2:0] in_at_done,
                       output logic busy1, output logic [2:0] in6,
                       output logic [2:0] in36,
                       output logic [7:0] hold_c, output logic hold_cv,
                       output logic hold_m);
    int cyc;
    first_done = 0;
    ndone = 0;
    c = 'x; cv = 'x; m = 'x; busy_at_done = 'x; in_at_done = 'x;
    busy1 = 'x; in6 = 'x; in36 = 'x;
    pulse_start();
    cyc = 1;
    repeat (60) begin
      if (cyc == 1) busy1 = busy;
      if (cyc == 6) in6 = dut_in;
      if (cyc == 36) in36 = dut_in;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = cyc;
          c = code; cv = code_valid; m = match;
          busy_at_done = busy; in_at_done = dut_in;
        end
      end
      if (repulse && cyc == 10) start = 1'b1;
      step();
      start = 1'b0;
      cyc++;
    end
    hold_c = code; hold_cv = code_valid; hold_m = match;
  endtask

  task automatic test_reset();
    checks++;
    if ({dut_in, busy, done, code, code_valid, match} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got dut_in=%b busy=%b done=%b code=%h cv=%b match=%b, want all zero",
               dut_in, busy, done, code, code_valid, match);
    end
    // Start on the first edge after release must be ignored.
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_edge_start: busy=%b, want 0", busy);
    end
    step();
  endtask

  task automatic test_sweep_c5();
    int fd, nd; logic [7:0] c, hc; logic cv, m, bd, b1, hcv, hm; logic [2:0] idn, i6, i36;
    gate_tt = 8'hC5; expected = 8'hC5;
    sweep(1'b0, fd, nd, c, cv, m, bd, idn, b1, i6, i36, hc, hcv, hm);
    checks++; if (fd !== 41) begin failures++; $display("FAIL c5_done_cycle: got %0d want 41", fd); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL c5_done_count: got %0d want 1", nd); end
    checks++; if (c !== 8'hC5) begin failures++; $display("FAIL c5_code: got %h want c5", c); end
    checks++; if ({cv, m} !== 2'b11) begin failures++; $display("FAIL c5_valid_match: got %b%b want 11", cv, m); end
    checks++; if ({bd, idn} !== 4'b0000) begin failures++; $display("FAIL c5_finish_idle_outputs: busy=%b dut_in=%b want 0/000", bd, idn); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL c5_busy_cycle1: got %b want 1", b1); end
    checks++; if (i6 !== 3'b001) begin failures++; $display("FAIL c5_row1_dut_in: got %b want 001", i6); end
    checks++; if (i36 !== 3'b111) begin failures++; $display("FAIL c5_row7_dut_in: got %b want 111", i36); end
    checks++; if ({hc, hcv, hm} !== {8'hC5, 2'b11}) begin failures++; $display("FAIL c5_idle_hold: code=%h cv=%b match=%b want c5/1/1", hc, hcv, hm); end
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_start_idle: busy=%b done=%b want 00", busy, done);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_start_idle_later: busy=%b want 0", busy);
    end
  endtask

  task automatic test_constants();
    int fd, nd; logic [7:0] c, hc; logic cv, m, bd, b1, hcv, hm; logic [2:0] idn, i6, i36;
    expected = 8'hC5;
    gate_tt = 8'h00;
    sweep(1'b0, fd, nd, c, cv, m, bd, idn, b1, i6, i36, hc, hcv, hm);
    checks++; if (c !== 8'h00) begin failures++; $display("FAIL const0_code: got %h want 00", c); end
    checks++; if ({cv, m} !== 2'b10) begin failures++; $display("FAIL const0_valid_match: got %b%b want 10", cv, m); end
    checks++; if (fd !== 41) begin failures++; $display("FAIL const0_done_cycle: got %0d want 41", fd); end
    gate_tt = 8'hFF;
    sweep(1'b0, fd, nd, c, cv, m, bd, idn, b1, i6, i36, hc, hcv, hm);
    checks++; if (c !== 8'hFF) begin failures++; $display("FAIL const1_code: got %h want ff", c); end
    checks++; if ({cv, m} !== 2'b10) begin failures++; $display("FAIL const1_valid_match: got %b%b want 10", cv, m); end
    checks++; if (hc !== 8'hFF) begin failures++; $display("FAIL const1_idle_hold: got %h want ff", hc); end
  endtask

  task automatic test_start_ignored();
    int fd, nd; logic [7:0] c, hc; logic cv, m, bd, b1, hcv, hm; logic [2:0] idn, i6, i36;
    gate_tt = 8'hC5; expected = 8'hC5;
    sweep(1'b1, fd, nd, c, cv, m, bd, idn, b1, i6, i36, hc, hcv, hm);
    checks++; if (nd !== 1) begin failures++; $display("FAIL repulse_done_count: got %0d want 1", nd); end
    checks++; if (fd !== 41) begin failures++; $display("FAIL repulse_done_cycle: got %0d want 41", fd); end
    checks++; if ({c, m} !== {8'hC5, 1'b1}) begin failures++; $display("FAIL repulse_code: code=%h match=%b want c5/1", c, m); end
  endtask

  task automatic test_abort();
    int ndone;
    gate_tt = 8'hC5;
    pulse_start();
    // Row 3 DRIVE begins at cycle 16; we are now in cycle 1.
    repeat (15) step();
    checks++;
    if ({busy, dut_in} !== 4'b1011) begin
      failures++;
      $display("FAIL abort_row3_setup: busy=%b dut_in=%b want 1/011", busy, dut_in);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, dut_in, code_valid, match, done} !== 7'b0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b dut_in=%b cv=%b match=%b done=%b want all zero",
               busy, dut_in, code_valid, match, done);
    end
    ndone = 0;
    repeat (50) begin
      if (done) ndone++;
      step();
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int fd, nd; logic [7:0] c, hc; logic cv, m, bd, b1, hcv, hm; logic [2:0] idn, i6, i36;
    gate_tt = 8'hC5; expected = 8'hC5;
    pulse_start();
    // Row 5 DRIVE begins at cycle 26.
    repeat (25) step();
    checks++;
    if (dut_in !== 3'b101) begin
      failures++;
      $display("FAIL reset_mid_setup: dut_in=%b want 101", dut_in);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dut_in, busy, done, code, code_valid, match} !== 14'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: dut_in=%b busy=%b done=%b code=%h cv=%b match=%b want all zero",
               dut_in, busy, done, code, code_valid, match);
    end
    step();
    #2;
    rst = 1'b0;
    step();
    sweep(1'b0, fd, nd, c, cv, m, bd, idn, b1, i6, i36, hc, hcv, hm);
    checks++; if (fd !== 41) begin failures++; $display("FAIL reset_mid_resweep_done: got %0d want 41", fd); end
    checks++; if ({c, cv, m} !== {8'hC5, 2'b11}) begin failures++; $display("FAIL reset_mid_resweep_code: code=%h cv=%b match=%b want c5/1/1", c, cv, m); end
  endtask

  task automatic test_settle3_delayed_gate();
    int cyc, fd, nd;
    logic [7:0] c;
    logic m, cv;
    fd = 0; nd = 0; c = 'x; m = 'x; cv = 'x;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    cyc = 1;
    repeat (50) begin
      if (done3) begin
        nd++;
        if (fd == 0) begin
          fd = cyc; c = code3; m = match3; cv = code_valid3;
        end
      end
      step();
      cyc++;
    end
    checks++; if (fd !== 33) begin failures++; $display("FAIL settle3_done_cycle: got %0d want 33", fd); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL settle3_done_count: got %0d want 1", nd); end
    checks++; if (c !== 8'hC5) begin failures++; $display("FAIL settle3_code: got %h want c5", c); end
    checks++; if ({cv, m} !== 2'b11) begin failures++; $display("FAIL settle3_valid_match: got %b%b want 11", cv, m); end
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    test_sweep_c5();
    test_abort_start_idle();
    test_constants();
    test_start_ignored();
    test_abort();
    test_reset_mid_sweep();
    test_settle3_delayed_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_extractor.md
TRUTH_TABLE_EXTRACTOR -- requirements
Module: truth_table_extractor

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning wait cycles after each input change before out is sampled (legal range 3..255).
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  terminate the sweep in progress.
REQ-006 SHALL have port expected  input  8  reference truth-table code used for comparison.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input gate under test, asynchronous to clk.
REQ-008 SHALL have port dut_in  output  3  stimulus to the gate under test: bit2=in1, bit1=in2, bit0=in3.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port code  output  8  extracted truth-table code.
REQ-012 SHALL have port code_valid  output  1  code holds a complete sweep result.
REQ-013 SHALL have port match  output  1  code equals expected; qualified by code_valid.

Function
REQ-014 SHALL implement states IDLE, DRIVE, SAMPLE and FINISH.
REQ-015 SHALL leave IDLE only on start=1 in IDLE; it then enters DRIVE with row=0, clears code_valid and sets busy=1.
REQ-016 SHALL drive dut_in = row ({in1,in2,in3}) throughout DRIVE and SAMPLE, and drive dut_in = 3'b000 in IDLE and FINISH.
REQ-017 SHALL stay in DRIVE for exactly SETTLE_CYCLES cycles per row, counted by a settle counter cleared on each row entry.
REQ-018 SHALL spend exactly one SAMPLE cycle per row, writing the synchronized dut_out into code bit (7 - row); for example, row 000 maps to bit 7 and row 111 maps to bit 0.
REQ-019 SHALL go from SAMPLE to DRIVE with row+1 when row<7, and to FINISH when row=7; row SHALL NOT wrap.
REQ-020 SHALL, in FINISH, pulse done for one cycle, set code_valid=1, set match=(code==expected), set busy=0, and return to IDLE the next cycle.
REQ-021 SHALL hold code, code_valid and match stable in IDLE until the next accepted start.
REQ-022 SHALL assert done exactly 1+8*(SETTLE_CYCLES+1) cycles after the start cycle (41 cycles at the default value).
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on abort=1 in any non-IDLE state, go to IDLE the next cycle with dut_in=000, busy=0, code_valid=0, match=0 and no done pulse; abort takes priority over FINISH completion.
REQ-025 SHALL treat abort and start in the same IDLE cycle as abort, so no sweep starts.
REQ-026 SHALL pass dut_out through a two-flop synchronizer before sampling; the SETTLE_CYCLES minimum of 3 covers the synchronizer latency.
REQ-027 SHALL evaluate match as unsigned 8-bit equality; match SHALL be 0 whenever code_valid=0.

Reset
REQ-028 SHALL, while rst=1, immediately force state=IDLE, row=0, settle counter=0, dut_in=000, busy=0, done=0, code=8'h00, code_valid=0, match=0, and clear the synchronizer flops.
REQ-029 SHALL, on reset during a sweep, discard all partial results, and SHALL accept no start until rst has been deasserted and one rising edge of clk has occurred.

Structure
REQ-030 SHALL take the state enum, ROWS=8 and CODE_W=8 from a shared package, truth_table_pkg.
REQ-031 SHALL instantiate one sub-module, sync2, as the dut_out synchronizer with asynchronous active-high reset.
REQ-032 SHALL size the settle counter as 8 bits and the row register as 3 bits.

Verification
REQ-033 Gate model m0xC5 (000,001,101,111 -> 1), expected=8'hC5, start -> done at cycle 41, code=8'hC5, code_valid=1, match=1.
REQ-034 Constant-0 gate then constant-1 gate, expected=8'hC5 -> code=8'h00 then 8'hFF, match=0 both times.
REQ-035 abort asserted while row=3 -> next cycle busy=0, dut_in=000, code_valid=0, no done within 50 cycles.
REQ-036 rst pulsed mid-sweep at row=5 -> all outputs at reset values immediately; a new start yields a correct full sweep.
REQ-037 start re-pulsed at cycle 10 of a sweep -> ignored; exactly one done, at cycle 41.
REQ-038 SETTLE_CYCLES=3 with a gate model that has 2 cycles of output delay -> code still 8'hC5, done at cycle 33.
